sub_bytes_enc_iter: RTL and testbench



---
 rtl/sub_bytes_enc_iter.sv | 161 ++++++++++++++++
 tb/tb_sub_bytes_enc_iter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_bytes_enc_iter.sv
`default_nettype none
// ============================================================================
// Module   : sub_bytes_enc_iter
// Brief    : Iterative AES SubBytes engine, LANES forward S-boxes per cycle,
//            valid/ready in and out. Optional SUBBYTES_ENC_INV_EN adds an
//            inv_mode port selecting the inverse S-box per block.
// Revision : 1.0
// ============================================================================
module sub_bytes_enc_iter #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] State_In,
`ifdef SUBBYTES_ENC_INV_EN
  input  logic         inv_mode,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] State_Out
);

  localparam int N  = 16 / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
    $error("sub_bytes_enc_iter: LANES must be 1, 2, 4, 8 or 16");
  end

  // Entry b occupies bits [8b : 8b+7].
  localparam logic [0:2047] C_SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
    return C_SBOX_FWD[{b, 3'b000} +: 8];
  endfunction

`ifdef SUBBYTES_ENC_INV_EN
  localparam logic [0:2047] C_SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox_inv(input logic [7:0] b);
    return C_SBOX_INV[{b, 3'b000} +: 8];
  endfunction
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [0:127]    r_work;
  logic [0:127]    w_work_upd;
`ifdef SUBBYTES_ENC_INV_EN
  logic            r_inv;
`endif

  logic [3:0] w_lane_idx [LANES];
  logic [7:0] w_lane_in  [LANES];
  logic [7:0] w_lane_out [LANES];

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign w_lane_idx[k] = 4'(32'(r_cnt) * LANES + k);
    assign w_lane_in[k]  = r_work[{w_lane_idx[k], 3'b000} +: 8];
`ifdef SUBBYTES_ENC_INV_EN
    assign w_lane_out[k] = r_inv ? sbox_inv(w_lane_in[k]) : sbox_fwd(w_lane_in[k]);
`else
    assign w_lane_out[k] = sbox_fwd(w_lane_in[k]);
`endif
  end

  always_comb begin
    w_work_upd = r_work;
    for (int k = 0; k < LANES; k++) begin
      w_work_upd[{w_lane_idx[k], 3'b000} +: 8] = w_lane_out[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = RUN;
      end
      RUN: begin
        if (r_cnt == C_LAST) w_state_nxt = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // cnt saturates at the last group so it never wraps inside a block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_work <= '0;
`ifdef SUBBYTES_ENC_INV_EN
      r_inv  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_work <= State_In;
            r_cnt  <= '0;
`ifdef SUBBYTES_ENC_INV_EN
            r_inv  <= inv_mode;
`endif
          end
        end
        RUN: begin
          r_work <= w_work_upd;
          if (r_cnt != C_LAST) r_cnt <= r_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign State_Out = r_work;

endmodule
`default_nettype wire

// File: tb/tb_sub_bytes_enc_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sub_bytes_enc_iter
// Brief    : Directed bench for sub_bytes_enc_iter at LANES = 4, 1, 2, 8, 16.
// Revision : 1.0
// ============================================================================
module tb_sub_bytes_enc_iter;

  localparam int NDUT = 5;

  localparam logic [0:127] C_APPB_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [0:127] C_APPB_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [0:127] C_SEQ_IN   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] C_SEQ_OUT  = 128'h637c777bf26b6fc53001672bfed7ab76;
  localparam logic [0:127] C_FF53_IN  = 128'hff530000000000000000000000000000;
  localparam logic [0:127] C_FF53_OUT = 128'h16ed6363636363636363636363636363;
  localparam logic [0:127] C_ZERO_OUT = 128'h63636363636363636363636363636363;

  function automatic int lanes_of(input int g);
    case (g)
      0:       return 4;
      1:       return 1;
      2:       return 2;
      3:       return 8;
      default: return 16;
    endcase
  endfunction

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [0:127] state_in = '0;
  logic         inv_mode = 1'b0;

  logic         in_rdy  [NDUT];
  logic         out_vld [NDUT];
  logic [0:127] st_out  [NDUT];

  int pass_cnt = 0;
  int chk_cnt  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    sub_bytes_enc_iter #(.LANES(lanes_of(g))) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_rdy[g]),
      .State_In  (state_in),
`ifdef SUBBYTES_ENC_INV_EN
      .inv_mode  (inv_mode),
`endif
      .out_valid (out_vld[g]),
      .out_ready (out_ready),
      .State_Out (st_out[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (20) tick();
  endtask

  // Sends one block to the LANES=4 instance and reports edges until out_valid.
  task automatic send_and_wait(input logic [0:127] v, output int lat, output logic [0:127] got);
    lat       = -1;
    got       = '0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    state_in  = v;
    tick();
    in_valid  = 1'b0;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      tick();
      if (out_vld[0]) begin
        lat = n;
        got = st_out[0];
      end
    end
  endtask

  task automatic test_reset();
    int lat;
    logic [0:127] got;
    rst_n = 1'b0;
    #3;
    chk_cnt++;
    if (in_rdy[0] !== 1'b1 || out_vld[0] !== 1'b0 || st_out[0] !== '0)
      $display("FAIL reset_state: in_ready=%b out_valid=%b out=%h, want 1 0 0", in_rdy[0], out_vld[0], st_out[0]);
    else pass_cnt++;
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    state_in  = C_APPB_IN;
    tick();
    in_valid  = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk_cnt++;
    if (in_rdy[0] !== 1'b1 || out_vld[0] !== 1'b0 || st_out[0] !== '0)
      $display("FAIL reset_mid_run: in_ready=%b out_valid=%b out=%h, want 1 0 0", in_rdy[0], out_vld[0], st_out[0]);
    else pass_cnt++;
    #2 rst_n = 1'b1;
    tick();
    send_and_wait('0, lat, got);
    chk_cnt++;
    if (lat !== 4 || got !== C_ZERO_OUT)
      $display("FAIL reset_then_zero: latency=%0d out=%h, want 4 %h", lat, got, C_ZERO_OUT);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_fips_round1();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    state_in  = C_APPB_IN;
    tick();
    in_valid  = 1'b0;
    state_in  = '1;
    for (int n = 1; n <= 5; n++) begin
      tick();
      chk_cnt++;
      if (out_vld[0] !== (n == 4) || in_rdy[0] !== (n == 5))
        $display("FAIL round1_handshake edge %0d: out_valid=%b in_ready=%b, want %b %b",
                 n, out_vld[0], in_rdy[0], (n == 4), (n == 5));
      else pass_cnt++;
      if (n == 4) begin
        chk_cnt++;
        if (st_out[0] !== C_APPB_OUT)
          $display("FAIL round1_data: out=%h, want %h", st_out[0], C_APPB_OUT);
        else pass_cnt++;
      end
    end
    drain();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    state_in  = C_SEQ_IN;
    tick();
    state_in  = C_APPB_IN;
    for (int n = 1; n <= 11; n++) begin
      tick();
      chk_cnt++;
      if (out_vld[0] !== (n == 4 || n == 10))
        $display("FAIL b2b_out_valid edge %0d: got %b, want %b", n, out_vld[0], (n == 4 || n == 10));
      else pass_cnt++;
      if (n == 4 || n == 10) begin
        chk_cnt++;
        if (st_out[0] !== ((n == 4) ? C_SEQ_OUT : C_APPB_OUT))
          $display("FAIL b2b_data edge %0d: out=%h, want %h", n, st_out[0],
                   (n == 4) ? C_SEQ_OUT : C_APPB_OUT);
        else pass_cnt++;
      end
      if (n == 6) in_valid = 1'b0;
    end
    drain();
  endtask

  task automatic test_backpressure();
    int bad_data = 0;
    int bad_rdy  = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    state_in  = C_SEQ_IN;
    tick();
    in_valid  = 1'b0;
    repeat (4) tick();
    chk_cnt++;
    if (out_vld[0] !== 1'b1 || st_out[0] !== C_SEQ_OUT)
      $display("FAIL bp_first: out_valid=%b out=%h, want 1 %h", out_vld[0], st_out[0], C_SEQ_OUT);
    else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      in_valid = ~in_valid;
      state_in = {$urandom, $urandom, $urandom, $urandom};
      tick();
      if (st_out[0] !== C_SEQ_OUT || out_vld[0] !== 1'b1) bad_data++;
      if (in_rdy[0] !== 1'b0) bad_rdy++;
    end
    chk_cnt++;
    if (bad_data !== 0) $display("FAIL bp_hold_data: %0d unstable cycles, want 0", bad_data);
    else pass_cnt++;
    chk_cnt++;
    if (bad_rdy !== 0) $display("FAIL bp_in_ready: %0d cycles with in_ready=1, want 0", bad_rdy);
    else pass_cnt++;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk_cnt++;
    if (out_vld[0] !== 1'b0 || in_rdy[0] !== 1'b1)
      $display("FAIL bp_release: out_valid=%b in_ready=%b, want 0 1", out_vld[0], in_rdy[0]);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_byte_order();
    int lat;
    logic [0:127] got;
    send_and_wait(C_SEQ_IN, lat, got);
    chk_cnt++;
    if (lat !== 4 || got !== C_SEQ_OUT)
      $display("FAIL byte_order: latency=%0d out=%h, want 4 %h", lat, got, C_SEQ_OUT);
    else pass_cnt++;
    drain();
    send_and_wait(C_FF53_IN, lat, got);
    chk_cnt++;
    if (lat !== 4 || got !== C_FF53_OUT)
      $display("FAIL table_ff_53: latency=%0d out=%h, want 4 %h", lat, got, C_FF53_OUT);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_lane_sweep();
    int lat [NDUT];
    logic [0:127] got [NDUT];
    for (int g = 0; g < NDUT; g++) begin
      lat[g] = -1;
      got[g] = '0;
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    state_in  = C_APPB_IN;
    tick();
    in_valid  = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      for (int g = 0; g < NDUT; g++) begin
        if (lat[g] < 0 && out_vld[g]) begin
          lat[g] = n;
          got[g] = st_out[g];
        end
      end
    end
    for (int g = 0; g < NDUT; g++) begin
      chk_cnt++;
      if (lat[g] !== 16 / lanes_of(g))
        $display("FAIL sweep_latency LANES=%0d: got %0d, want %0d", lanes_of(g), lat[g], 16 / lanes_of(g));
      else pass_cnt++;
      chk_cnt++;
      if (got[g] !== C_APPB_OUT)
        $display("FAIL sweep_data LANES=%0d: got %h, want %h", lanes_of(g), got[g], C_APPB_OUT);
      else pass_cnt++;
    end
    drain();
  endtask

`ifdef SUBBYTES_ENC_INV_EN
  task automatic test_inv_mode();
    int lat;
    logic [0:127] got;
    inv_mode = 1'b1;
    send_and_wait(C_APPB_OUT, lat, got);
    inv_mode = 1'b0;
    chk_cnt++;
    if (lat !== 4 || got !== C_APPB_IN)
      $display("FAIL inv_mode: latency=%0d out=%h, want 4 %h", lat, got, C_APPB_IN);
    else pass_cnt++;
    drain();
  endtask
`endif

  initial begin
    test_reset();
    test_fips_round1();
    test_back_to_back();
    test_backpressure();
    test_byte_order();
    test_lane_sweep();
`ifdef SUBBYTES_ENC_INV_EN
    test_inv_mode();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire
